// File: rtl/pipe_decode.sv
// rtl/pipe_decode.sv - RV32I field decoder feeding a small FIFO of pre-decoded instructions.
// The decode is combinational on the input side; every out_* port comes from FIFO storage registers.
module pipe_decode #(
   parameter int BUF_DEPTH = 2,
   parameter int PC_W      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     out_instr_o,
   output logic [PC_W-1:0] out_pc_o,
   output logic [4:0]      sel_rs1_o,
   output logic [4:0]      sel_rs2_o,
   output logic [4:0]      rd_o,
   output logic [31:0]     imm_o,
   output logic [2:0]      fmt_o,
   output logic            illegal_o,
   output logic [2:0]      count_o
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd6;

   logic [6:0]  opcode;
   logic [2:0]  dec_fmt;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic [31:0] dec_imm;
   logic        dec_ill;

   always_comb begin
      opcode  = instr_i[6:0];
      dec_fmt = FMT_ILL;
      dec_rs1 = '0;
      dec_rs2 = '0;
      dec_rd  = '0;
      dec_imm = '0;
      case (opcode)
         7'b0110011: begin
            dec_fmt = FMT_R;
            dec_rs1 = instr_i[19:15];
            dec_rs2 = instr_i[24:20];
            dec_rd  = instr_i[11:7];
         end
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
            dec_fmt = FMT_I;
            dec_rs1 = instr_i[19:15];
            dec_rd  = instr_i[11:7];
            dec_imm = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         // FENCE is I-format but never reads a source register.
         7'b0001111: begin
            dec_fmt = FMT_I;
            dec_rd  = instr_i[11:7];
            dec_imm = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            dec_rs1 = instr_i[19:15];
            dec_rs2 = instr_i[24:20];
            dec_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            dec_rs1 = instr_i[19:15];
            dec_rs2 = instr_i[24:20];
            dec_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            dec_rd  = instr_i[11:7];
            dec_imm = {instr_i[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            dec_rd  = instr_i[11:7];
            dec_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
         end
         default: begin
            dec_fmt = FMT_ILL;
         end
      endcase
      dec_ill = (dec_fmt == FMT_ILL);
   end

   logic [31:0]     instr_q [BUF_DEPTH];
   logic [31:0]     instr_d [BUF_DEPTH];
   logic [PC_W-1:0] pc_q    [BUF_DEPTH];
   logic [PC_W-1:0] pc_d    [BUF_DEPTH];
   logic [4:0]      rs1_q   [BUF_DEPTH];
   logic [4:0]      rs1_d   [BUF_DEPTH];
   logic [4:0]      rs2_q   [BUF_DEPTH];
   logic [4:0]      rs2_d   [BUF_DEPTH];
   logic [4:0]      rd_q    [BUF_DEPTH];
   logic [4:0]      rd_d    [BUF_DEPTH];
   logic [31:0]     imm_q   [BUF_DEPTH];
   logic [31:0]     imm_d   [BUF_DEPTH];
   logic [2:0]      fmt_q   [BUF_DEPTH];
   logic [2:0]      fmt_d   [BUF_DEPTH];
   logic            ill_q   [BUF_DEPTH];
   logic            ill_d   [BUF_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;
   logic             push, pop;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign in_ready_o  = (count_q < 3'(BUF_DEPTH));
   assign out_valid_o = (count_q != 3'd0);
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      imm_d    = imm_q;
      fmt_d    = fmt_q;
      ill_d    = ill_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = instr_i;
            pc_d[wr_ptr_q]    = pc_i;
            rs1_d[wr_ptr_q]   = dec_rs1;
            rs2_d[wr_ptr_q]   = dec_rs2;
            rd_d[wr_ptr_q]    = dec_rd;
            imm_d[wr_ptr_q]   = dec_imm;
            fmt_d[wr_ptr_q]   = dec_fmt;
            ill_d[wr_ptr_q]   = dec_ill;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + 3'd1;
         end else if (pop && !push) begin
            count_d = count_q - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
            rs1_q[i]   <= '0;
            rs2_q[i]   <= '0;
            rd_q[i]    <= '0;
            imm_q[i]   <= '0;
            fmt_q[i]   <= '0;
            ill_q[i]   <= 1'b0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         imm_q    <= imm_d;
         fmt_q    <= fmt_d;
         ill_q    <= ill_d;
      end
   end

   assign out_instr_o = instr_q[rd_ptr_q];
   assign out_pc_o    = pc_q[rd_ptr_q];
   assign sel_rs1_o   = rs1_q[rd_ptr_q];
   assign sel_rs2_o   = rs2_q[rd_ptr_q];
   assign rd_o        = rd_q[rd_ptr_q];
   assign imm_o       = imm_q[rd_ptr_q];
   assign fmt_o       = fmt_q[rd_ptr_q];
   assign illegal_o   = ill_q[rd_ptr_q];
   assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_decode.sv
// tb/tb_pipe_decode.sv - directed bench for pipe_decode with a queue-based reference model.
module tb_pipe_decode;
   localparam int DEPTH = 2;
   localparam int PC_W  = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [31:0]     instr_i;
   logic [PC_W-1:0] pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [31:0]     out_instr_o;
   logic [PC_W-1:0] out_pc_o;
   logic [4:0]      sel_rs1_o;
   logic [4:0]      sel_rs2_o;
   logic [4:0]      rd_o;
   logic [31:0]     imm_o;
   logic [2:0]      fmt_o;
   logic            illegal_o;
   logic [2:0]      count_o;

   pipe_decode #(.BUF_DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
      .sel_rs1_o(sel_rs1_o), .sel_rs2_o(sel_rs2_o), .rd_o(rd_o),
      .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   typedef struct packed {
      logic [2:0]  fmt;
      logic        ill;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
   } dec_t;

   ent_t mq[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode built from the ISA field rules using signed shifts.
   function automatic dec_t ref_decode(input logic [31:0] w);
      dec_t d;
      logic signed [31:0] s;
      logic use_rs1, use_rs2, use_rd;
      s = $signed(w);
      d = '0;
      case (w[6:0])
         7'h33:                                d.fmt = 3'd0;
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F:    d.fmt = 3'd1;
         7'h23:                                d.fmt = 3'd2;
         7'h63:                                d.fmt = 3'd3;
         7'h37, 7'h17:                         d.fmt = 3'd4;
         7'h6F:                                d.fmt = 3'd5;
         default:                              d.fmt = 3'd6;
      endcase
      use_rs1 = (d.fmt <= 3'd3) && (w[6:0] != 7'h0F);
      use_rs2 = (d.fmt == 3'd0) || (d.fmt == 3'd2) || (d.fmt == 3'd3);
      use_rd  = (d.fmt == 3'd0) || (d.fmt == 3'd1) || (d.fmt == 3'd4) || (d.fmt == 3'd5);
      d.ill = (d.fmt == 3'd6);
      if (use_rs1) d.rs1 = w[19:15];
      if (use_rs2) d.rs2 = w[24:20];
      if (use_rd)  d.rd  = w[11:7];
      case (d.fmt)
         3'd1: d.imm = 32'(s >>> 20);
         3'd2: d.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]);
         3'd3: d.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11)
                     | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         3'd4: d.imm = w & 32'hFFFF_F000;
         3'd5: d.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12)
                     | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         default: d.imm = 32'd0;
      endcase
      return d;
   endfunction

   always @(posedge clk) begin
      if (!rst_n || flush_i) begin
         mq.delete();
      end else begin
         bit do_pop;
         bit do_push;
         do_pop  = (mq.size() != 0) && out_ready_i;
         do_push = in_valid_i && (mq.size() < DEPTH);
         if (do_pop) mq.delete(0);
         if (do_push) mq.push_back('{instr: instr_i, pc: pc_i});
      end
   end

   always @(negedge clk) begin
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("out_valid", 32'(out_valid_o), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready_o), 32'(mq.size() < DEPTH));
      if (mq.size() != 0) begin
         dec_t e;
         e = ref_decode(mq[0].instr);
         chk("m_instr", out_instr_o, mq[0].instr);
         chk("m_pc", out_pc_o, mq[0].pc);
         chk("m_fmt", 32'(fmt_o), 32'(e.fmt));
         chk("m_illegal", 32'(illegal_o), 32'(e.ill));
         chk("m_rs1", 32'(sel_rs1_o), 32'(e.rs1));
         chk("m_rs2", 32'(sel_rs2_o), 32'(e.rs2));
         chk("m_rd", 32'(rd_o), 32'(e.rd));
         chk("m_imm", imm_o, e.imm);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
   localparam logic [31:0] I_JAL  = 32'h008000EF;

   logic [31:0] tbl [12];
   logic [31:0] got [$];
   logic [7:0]  rdy_pat;
   int          maxc;
   int          idx;
   bit          c_sent;
   bit          acc;

   initial begin
      tbl = '{32'hFFF08293, 32'h0021A423, 32'h0FF5800F, 32'h00000073,
              32'h000080E7, 32'hFFC12083, 32'h123453B7, 32'h00001517,
              32'hFFFFFFFF, 32'h4010D093, I_BEQ, I_JAL};
      rdy_pat = 8'b1011_0010;

      rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1;
      instr_i = 32'hDEADBEEF; pc_i = 32'h44; out_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", 32'(count_o), 0);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 1);
      chk("rst_instr", out_instr_o, 0);
      chk("rst_pc", out_pc_o, 0);
      chk("rst_fmt", 32'(fmt_o), 0);
      chk("rst_illegal", 32'(illegal_o), 0);
      chk("rst_idx", {17'd0, sel_rs1_o, sel_rs2_o, rd_o}, 0);
      chk("rst_imm", imm_o, 0);

      rst_n = 1'b1; in_valid_i = 1'b1; instr_i = 32'hFFF08293; pc_i = 32'h100; out_ready_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      chk("addi_valid", 32'(out_valid_o), 1);
      chk("addi_fmt", 32'(fmt_o), 1);
      chk("addi_rs1", 32'(sel_rs1_o), 1);
      chk("addi_rs2", 32'(sel_rs2_o), 0);
      chk("addi_rd", 32'(rd_o), 5);
      chk("addi_imm", imm_o, 32'hFFFFFFFF);
      chk("addi_pc", out_pc_o, 32'h100);
      step();

      in_valid_i = 1'b1; instr_i = 32'h0021A423; pc_i = 32'h104; out_ready_i = 1'b0;
      step();
      in_valid_i = 1'b0;
      chk("sw_fmt", 32'(fmt_o), 2);
      chk("sw_rs1", 32'(sel_rs1_o), 3);
      chk("sw_rs2", 32'(sel_rs2_o), 2);
      chk("sw_rd", 32'(rd_o), 0);
      chk("sw_imm", imm_o, 32'h8);
      step();
      chk("sw_hold_imm", imm_o, 32'h8);
      out_ready_i = 1'b1;
      step();

      in_valid_i = 1'b1; instr_i = 32'h0; pc_i = 32'h108;
      step();
      in_valid_i = 1'b0;
      chk("ill_fmt", 32'(fmt_o), 6);
      chk("ill_flag", 32'(illegal_o), 1);
      chk("ill_idx", {17'd0, sel_rs1_o, sel_rs2_o, rd_o}, 0);
      chk("ill_imm", imm_o, 0);
      chk("ill_instr", out_instr_o, 0);
      chk("ill_pc", out_pc_o, 32'h108);
      step();

      out_ready_i = 1'b0;
      in_valid_i = 1'b1; instr_i = I_ADD; pc_i = 32'h200;
      step();
      instr_i = I_BEQ; pc_i = 32'h204;
      step();
      instr_i = I_JAL; pc_i = 32'h208;
      chk("full_in_ready", 32'(in_ready_o), 0);
      chk("full_count", 32'(count_o), 2);
      step();
      step();
      chk("held_in_ready", 32'(in_ready_o), 0);
      out_ready_i = 1'b1;
      got.delete();
      maxc = 0;
      c_sent = 1'b0;
      for (int k = 0; k < 12 && got.size() < 3; k++) begin
         if (int'(count_o) > maxc) maxc = int'(count_o);
         if (out_valid_o && out_ready_i) begin
            got.push_back(out_instr_o);
            if (out_instr_o == I_BEQ) begin
               chk("beq_imm", imm_o, 32'hFFFFFFFC);
               chk("beq_fmt", 32'(fmt_o), 3);
            end
            if (out_instr_o == I_JAL) begin
               chk("jal_imm", imm_o, 32'h8);
               chk("jal_rd", 32'(rd_o), 1);
            end
         end
         if (in_valid_i && in_ready_o) c_sent = 1'b1;
         step();
         if (c_sent) in_valid_i = 1'b0;
      end
      chk("order_n", 32'(got.size()), 3);
      while (got.size() < 3) got.push_back(32'hX);
      chk("order_0", got[0], I_ADD);
      chk("order_1", got[1], I_BEQ);
      chk("order_2", got[2], I_JAL);
      chk("max_count_le2", 32'(maxc <= 2), 1);

      out_ready_i = 1'b0; in_valid_i = 1'b1;
      instr_i = 32'h123453B7; pc_i = 32'h300;
      step();
      instr_i = 32'h00001517; pc_i = 32'h304;
      step();
      flush_i = 1'b1; instr_i = 32'h00100073; pc_i = 32'h308;
      step();
      flush_i = 1'b0; in_valid_i = 1'b0;
      chk("flush_count", 32'(count_o), 0);
      chk("flush_valid", 32'(out_valid_o), 0);
      chk("flush_ready", 32'(in_ready_o), 1);
      out_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("flush_gone", 32'(out_valid_o), 0);
      end

      idx = 0;
      for (int c = 0; c < 40; c++) begin
         in_valid_i  = (c % 4 != 3);
         out_ready_i = rdy_pat[c % 8];
         flush_i     = (c == 17);
         rst_n       = !(c == 29);
         instr_i     = tbl[idx % 12];
         pc_i        = 32'h400 + 32'(4 * idx);
         acc         = in_valid_i && in_ready_o;
         step();
         if (acc) idx++;
      end
      rst_n = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
